collatz_sweep_seq: RTL and testbench

Host-side sequencer sitting directly upstream of the Collatz tile. It drives the tile's byte-wide I/O protocol to run a sweep of consecutive starting values. For each value it resets the tile, loads the value, pulses compute, and waits for completion. It then reads back orbit length and path-record bytes and emits one result record per value over a valid/ready stream.

---
 rtl/collatz_sweep_pkg.sv | 25 ++
 rtl/collatz_sweep_seq_rd_capture.sv | 54 +++++
 rtl/collatz_sweep_seq.sv | 150 +++++++++++++++
 tb/tb_collatz_sweep_seq.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/collatz_sweep_pkg.sv
// Shared definitions for the Collatz sweep sequencer: FSM states, tile
// protocol bit positions and the orbit code reported for a timed-out run.
package collatz_sweep_pkg;

  localparam int ENG_BYTES_DEFAULT = 18;

  localparam int UIO_WR_BIT   = 7;
  localparam int UIO_GO_BIT   = 6;
  localparam int UIO_PATH_BIT = 5;

  localparam logic [15:0] TIMEOUT_ORBIT = 16'hFFFF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ERST,
    S_WRITE,
    S_START,
    S_WAIT_RUN,
    S_WAIT_DONE,
    S_READ,
    S_ABORT,
    S_EMIT
  } state_t;

endpackage

// File: rtl/collatz_sweep_seq_rd_capture.sv
// Read-back unit: walks the four tile reads (orbit lo/hi, path lo/hi), holds
// each address for two cycles and captures the registered tile data at the
// end of the second cycle, assembling two 16-bit words.
module collatz_rd_capture (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        active,
  input  logic [7:0]  rd_data,
  output logic [5:0]  rd_sel,
  output logic        done,
  output logic [15:0] orbit_word,
  output logic [15:0] path_word
);

  // cnt[2] selects the path record, cnt[1] the byte address, cnt[0] the hold phase
  logic [2:0] cnt;

  // Step through the read sequence and capture a byte on every second cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 3'd0;
      orbit_word <= 16'd0;
      path_word  <= 16'd0;
    end else if (clear) begin
      cnt        <= 3'd0;
      orbit_word <= 16'd0;
      path_word  <= 16'd0;
    end else if (!active) begin
      cnt <= 3'd0;
    end else begin
      cnt <= cnt + 3'd1;
      if (cnt[0]) begin
        case (cnt[2:1])
          2'd0:    orbit_word[7:0]  <= rd_data;
          2'd1:    orbit_word[15:8] <= rd_data;
          2'd2:    path_word[7:0]   <= rd_data;
          default: path_word[15:8]  <= rd_data;
        endcase
      end
    end
  end

  // Address presented to the tile and end-of-sequence flag
  always_comb begin
    rd_sel = 6'd0;
    done   = 1'b0;
    if (active) begin
      rd_sel = {cnt[2], 4'b0000, cnt[1]};
      done   = (cnt == 3'd7);
    end
  end

endmodule

// File: rtl/collatz_sweep_seq.sv
// Sweep sequencer: for each starting value it resets the Collatz tile, loads
// the value byte by byte, pulses compute, waits for the run, reads back the
// orbit length and path record and emits one result record.
module collatz_sweep_seq
  import collatz_sweep_pkg::*;
#(
  parameter int START_W   = 32,
  parameter int ENG_BYTES = ENG_BYTES_DEFAULT,
  parameter int TIMEOUT_W = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  input  logic [START_W-1:0] cmd_base,
  input  logic [15:0]        cmd_count,
  output logic               seq_busy,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [START_W-1:0] res_start,
  output logic [15:0]        res_orbit_len,
  output logic [15:0]        res_path_h16,
  output logic               res_timeout,
  output logic               eng_rst_n,
  output logic [7:0]         eng_ui,
  output logic [7:0]         eng_uio,
  input  logic [7:0]         eng_uo,
  input  logic               eng_oe7
);

  state_t               state, state_next;
  logic [START_W-1:0]   cur_value;
  logic [15:0]          remaining;
  logic [4:0]           idx;
  logic [TIMEOUT_W-1:0] wd;
  logic                 timed_out;
  logic                 oe7_q;
  logic [5:0]           rd_sel;
  logic                 rd_done;
  logic [15:0]          orbit_word;
  logic [15:0]          path_word;
  logic [7:0]           wr_byte;

  collatz_rd_capture u_rd (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (state == S_ERST),
    .active     (state == S_READ),
    .rd_data    (eng_uo),
    .rd_sel     (rd_sel),
    .done       (rd_done),
    .orbit_word (orbit_word),
    .path_word  (path_word)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state decode; the watchdog bounds both waits so a silent tile cannot hang the sweep
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (cmd_valid && cmd_count != 16'd0) state_next = S_ERST;
      S_ERST:      state_next = S_WRITE;
      S_WRITE:     if (idx == 5'(ENG_BYTES - 1)) state_next = S_START;
      S_START:     state_next = S_WAIT_RUN;
      S_WAIT_RUN:  if (oe7_q) state_next = S_WAIT_DONE;
                   else if (&wd) state_next = S_ABORT;
      S_WAIT_DONE: if (!oe7_q) state_next = S_READ;
                   else if (&wd) state_next = S_ABORT;
      S_READ:      if (rd_done) state_next = S_EMIT;
      S_ABORT:     state_next = S_EMIT;
      S_EMIT:      if (res_ready) state_next = (remaining == 16'd1) ? S_IDLE : S_ERST;
      default:     state_next = S_IDLE;
    endcase
  end

  // Sweep datapath: value/count bookkeeping, byte index, watchdog and tile-busy sampling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_value <= '0;
      remaining <= 16'd0;
      idx       <= 5'd0;
      wd        <= '0;
      timed_out <= 1'b0;
      oe7_q     <= 1'b0;
    end else begin
      oe7_q <= eng_oe7;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_count != 16'd0) begin
            cur_value <= cmd_base;
            remaining <= cmd_count;
          end
        end
        S_ERST: begin
          idx       <= 5'd0;
          timed_out <= 1'b0;
        end
        S_WRITE:  idx <= idx + 5'd1;
        S_START:  wd  <= '0;
        S_WAIT_RUN, S_WAIT_DONE: begin
          wd <= wd + TIMEOUT_W'(1);
          if (state_next == S_ABORT) timed_out <= 1'b1;
        end
        S_EMIT: begin
          if (res_ready) begin
            cur_value <= cur_value + START_W'(1);
            remaining <= remaining - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Select the value byte for the current write address; addresses past the value width load zero
  always_comb begin
    wr_byte = 8'h00;
    for (int b = 0; b < START_W / 8; b++) begin
      if (idx == 5'(b)) wr_byte = cur_value[b*8 +: 8];
    end
  end

  // Tile drive and result presentation, decoded from the registered state
  always_comb begin
    eng_uio   = 8'h00;
    eng_ui    = 8'h00;
    eng_rst_n = !(state == S_ERST || state == S_ABORT);
    case (state)
      S_WRITE: begin
        eng_uio[UIO_WR_BIT] = 1'b1;
        eng_uio[4:0]        = idx;
        eng_ui              = wr_byte;
      end
      S_START: eng_uio[UIO_GO_BIT] = 1'b1;
      S_READ:  eng_uio[UIO_PATH_BIT:0] = rd_sel;
      default: ;
    endcase
    seq_busy      = (state != S_IDLE);
    res_valid     = (state == S_EMIT);
    res_start     = cur_value;
    res_timeout   = timed_out;
    res_orbit_len = timed_out ? TIMEOUT_ORBIT : orbit_word;
    res_path_h16  = path_word;
  end

endmodule

// File: tb/tb_collatz_sweep_seq.sv
// Testbench for collatz_sweep_seq: a behavioural Collatz tile is attached,
// commands are issued with randomized values, and a scoreboard compares
// every emitted record against a plain-arithmetic reference model.
module tb_collatz_sweep_seq;

  localparam int START_W   = 32;
  localparam int ENG_BYTES = 18;
  localparam int TIMEOUT_W = 12;
  localparam int STEP_CAP  = 3000;

  typedef struct packed {
    logic [31:0] start;
    logic [15:0] orbit;
    logic [15:0] path;
    logic        tmo;
  } rec_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cmd_valid;
  logic [START_W-1:0] cmd_base;
  logic [15:0]        cmd_count;
  logic               seq_busy;
  logic               res_valid;
  logic               res_ready;
  logic [START_W-1:0] res_start;
  logic [15:0]        res_orbit_len;
  logic [15:0]        res_path_h16;
  logic               res_timeout;
  logic               eng_rst_n;
  logic [7:0]         eng_ui;
  logic [7:0]         eng_uio;
  logic [7:0]         eng_uo;
  logic               eng_oe7;

  int   checks   = 0;
  int   failures = 0;
  rec_t sb[$];
  logic hold_ready = 1'b0;

  collatz_sweep_seq #(
    .START_W   (START_W),
    .ENG_BYTES (ENG_BYTES),
    .TIMEOUT_W (TIMEOUT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_base      (cmd_base),
    .cmd_count     (cmd_count),
    .seq_busy      (seq_busy),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_start     (res_start),
    .res_orbit_len (res_orbit_len),
    .res_path_h16  (res_path_h16),
    .res_timeout   (res_timeout),
    .eng_rst_n     (eng_rst_n),
    .eng_ui        (eng_ui),
    .eng_uio       (eng_uio),
    .eng_uo        (eng_uo),
    .eng_oe7       (eng_oe7)
  );

  always #5 clk = ~clk;

  function automatic logic [143:0] collatzStep(input logic [143:0] x);
    return x[0] ? (x + (x << 1) + 144'd1) : (x >> 1);
  endfunction

  // Behavioural tile: byte-wide workhorse register, one Collatz step per
  // compute cycle, orbit length and path maximum cleared only by its reset
  logic [143:0] treg  = '0;
  logic [143:0] tx    = '0;
  logic [143:0] tpath = '0;
  logic [15:0]  torbit = 16'd0;
  logic         tbusy  = 1'b0;
  logic [7:0]   tuo    = 8'd0;

  assign eng_uo  = tuo;
  assign eng_oe7 = tbusy;

  always @(posedge clk) begin
    if (!eng_rst_n) begin
      torbit <= 16'd0;
      tpath  <= '0;
      tbusy  <= 1'b0;
      tuo    <= 8'd0;
    end else if (tbusy) begin
      tx     <= collatzStep(tx);
      torbit <= torbit + 16'd1;
      if (collatzStep(tx) > tpath) tpath <= collatzStep(tx);
      if (collatzStep(tx) == 144'd1) tbusy <= 1'b0;
    end else begin
      if (eng_uio[7] && eng_uio[4:0] < 5'd18) treg[eng_uio[4:0]*8 +: 8] <= eng_ui;
      if (eng_uio[6]) begin
        tbusy <= 1'b1;
        tx    <= treg;
      end
      if (eng_uio[5]) tuo <= eng_uio[0] ? tpath[31:24] : tpath[23:16];
      else            tuo <= eng_uio[0] ? torbit[15:8] : torbit[7:0];
    end
  end

  // Reference: iterate the Collatz rule until 1, tracking steps and the peak value
  function automatic rec_t refModel(input logic [31:0] v);
    rec_t         e;
    logic [143:0] x;
    logic [143:0] mx;
    int           steps;
    x     = {112'd0, v};
    mx    = '0;
    steps = 0;
    do begin
      x = collatzStep(x);
      steps++;
      if (x > mx) mx = x;
    end while (x != 144'd1 && steps < STEP_CAP);
    e.start = v;
    if (x != 144'd1) begin
      e.orbit = 16'hFFFF;
      e.path  = 16'h0000;
      e.tmo   = 1'b1;
    end else begin
      e.orbit = 16'(steps);
      e.path  = mx[31:16];
      e.tmo   = 1'b0;
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic waitIdle(input int max_cycles, input string name);
    int n;
    n = 0;
    while ((seq_busy || sb.size() != 0) && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput(name, {127'd0, (n >= max_cycles)}, 128'd0);
  endtask

  task automatic applyStimulus(input logic [31:0] base, input logic [15:0] count);
    logic [31:0] v;
    int          n;
    n = 0;
    while (seq_busy && n < 40000) begin
      @(posedge clk);
      n++;
    end
    v = base;
    for (int i = 0; i < count; i++) begin
      sb.push_back(refModel(v));
      v = v + 32'd1;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_base  = base;
    cmd_count = count;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    checkOutput("busy_after_cmd", {127'd0, seq_busy}, {127'd0, (count != 16'd0)});
  endtask

  // Drive res_ready just after each rising edge: random backpressure unless held low
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_ready) res_ready = 1'b0;
      else            res_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pop the scoreboard on every handshake and check tile reset pulses are one cycle
  initial begin
    rec_t exp_rec;
    int   low_len;
    low_len = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        low_len = 0;
      end else begin
        if (!eng_rst_n) low_len++;
        else if (low_len != 0) begin
          checkOutput("eng_rst_pulse_len", 128'(low_len), 128'd1);
          low_len = 0;
        end
        if (res_valid && res_ready) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_record", {96'd0, res_start}, 128'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            exp_rec = sb.pop_front();
            checkOutput("res_start",     {96'd0, res_start},      {96'd0, exp_rec.start});
            checkOutput("res_orbit_len", {112'd0, res_orbit_len}, {112'd0, exp_rec.orbit});
            checkOutput("res_path_h16",  {112'd0, res_path_h16},  {112'd0, exp_rec.path});
            checkOutput("res_timeout",   {127'd0, res_timeout},   {127'd0, exp_rec.tmo});
          end
        end
      end
    end
  end

  initial begin
    logic [75:0] snap;
    int          n;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_base  = '0;
    cmd_count = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs",
                {55'd0, seq_busy, res_valid, res_start, res_orbit_len, res_path_h16, res_timeout, eng_uio, eng_ui, eng_rst_n},
                {55'd0, 2'b00, 32'd0, 16'd0, 16'd0, 1'b0, 8'd0, 8'd0, 1'b1});
    rst_n = 1'b1;

    $display("[TB] single value 27");
    applyStimulus(32'd27, 16'd1);
    waitIdle(5000, "wait_27");

    $display("[TB] values 1 and 2");
    applyStimulus(32'd1, 16'd2);
    waitIdle(5000, "wait_1_2");

    $display("[TB] value 0 times out");
    applyStimulus(32'd0, 16'd1);
    waitIdle(10000, "wait_0");
    checkOutput("tile_idle_after_abort", {127'd0, eng_oe7}, 128'd0);

    $display("[TB] zero-count command");
    applyStimulus(32'd5, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("zero_count_idle", {119'd0, seq_busy, eng_uio}, 128'd0);

    $display("[TB] result stall");
    hold_ready = 1'b1;
    applyStimulus(32'd27, 16'd1);
    n = 0;
    while (!res_valid && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("stall_reach_emit", {127'd0, res_valid}, 128'd1);
    snap = {res_valid, seq_busy, eng_rst_n, eng_uio, res_start, res_orbit_len, res_path_h16, res_timeout};
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      checkOutput("stall_stable",
                  {52'd0, res_valid, seq_busy, eng_rst_n, eng_uio, res_start, res_orbit_len, res_path_h16, res_timeout},
                  {52'd0, snap});
    end
    hold_ready = 1'b0;
    waitIdle(5000, "wait_stall");

    $display("[TB] start value wrap");
    applyStimulus(32'hFFFF_FFFF, 16'd2);
    waitIdle(20000, "wait_wrap");

    $display("[TB] random sweeps");
    for (int r = 0; r < 6; r++) begin
      applyStimulus($urandom, 16'($urandom_range(1, 3)));
      waitIdle(20000, "wait_random");
    end

    $display("[TB] reset during compute");
    applyStimulus(32'd27, 16'd3);
    n = 0;
    while (!eng_oe7 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("async_reset_outputs",
                {55'd0, seq_busy, res_valid, res_start, res_orbit_len, res_path_h16, res_timeout, eng_uio, eng_ui, eng_rst_n},
                {55'd0, 2'b00, 32'd0, 16'd0, 16'd0, 1'b0, 8'd0, 8'd0, 1'b1});
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(32'd27, 16'd1);
    waitIdle(5000, "wait_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
